// File: rtl/addsub_pipe_if.sv
// Handshake and operand/result bundle for addsub_pipe.
// Carries the optional sat sideband when ADDSUB_SAT_EN is defined.
interface addsub_pipe_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic         op;
    logic         carryin;
    logic [N-1:0] X;
    logic [N-1:0] Y;
`ifdef ADDSUB_SAT_EN
    logic         sat;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] S;
    logic         carryout;
    logic         overflow;
    logic         zero;
    logic         negative;

    // Producer/consumer side (testbench or upstream logic)
    modport master (
`ifdef ADDSUB_SAT_EN
        output sat,
`endif
        output in_valid, op, carryin, X, Y, out_ready,
        input  in_ready, out_valid, S, carryout, overflow, zero, negative
    );

    // The pipelined adder itself
    modport slave (
`ifdef ADDSUB_SAT_EN
        input  sat,
`endif
        input  in_valid, op, carryin, X, Y, out_ready,
        output in_ready, out_valid, S, carryout, overflow, zero, negative
    );
endinterface

// File: rtl/addsub_pipe.sv
// Pipelined N-bit adder/subtractor, one W=N/STAGES chunk per stage, with
// carry-out, signed overflow, zero and negative flags. Valid/ready on both
// sides; the whole pipe stalls when the output is held.
// Optional macro ADDSUB_SAT_EN adds a per-beat sat bit that clamps S to the
// most positive/negative value on signed overflow, with no added latency.
module addsub_pipe #(
    parameter int N      = 32,
    parameter int STAGES = 4
) (
    input logic          clock,
    input logic          resetn,
    addsub_pipe_if.slave bus
);
    localparam int unsigned W = N / STAGES;
    localparam int unsigned L = STAGES - 1;

    if (STAGES < 1 || (N % STAGES) != 0) begin : g_bad_cfg
        $error("addsub_pipe: N must be a positive multiple of STAGES");
    end

    // Stage registers; r_s accumulates finished chunks, r_x/r_b keep the
    // operands so later stages can pick their own chunk.
    logic         r_v  [STAGES];
    logic [N-1:0] r_x  [STAGES];
    logic [N-1:0] r_b  [STAGES];
    logic [N-1:0] r_s  [STAGES];
    logic         r_c  [STAGES];
    logic         r_z  [STAGES];
    logic         r_xm [STAGES];
    logic         r_bm [STAGES];
`ifdef ADDSUB_SAT_EN
    logic         r_sat[STAGES];
    logic         w_sat[STAGES];
`endif

    // Per-stage inputs (stage 0 from the bus, stage k from register k-1)
    logic         w_v  [STAGES];
    logic [N-1:0] w_x  [STAGES];
    logic [N-1:0] w_b  [STAGES];
    logic [N-1:0] w_s  [STAGES];
    logic         w_c  [STAGES];
    logic         w_z  [STAGES];
    logic         w_xm [STAGES];
    logic         w_bm [STAGES];
    // Per-stage results
    logic [W:0]   w_add[STAGES];
    logic [N-1:0] w_sn [STAGES];
    logic         w_zn [STAGES];

    logic         w_adv;
    logic [N-1:0] w_s_raw;
    logic         w_ovf;

    // Global advance: the pipe moves whenever the output slot is free or taken
    always_comb begin
        w_adv = !r_v[L] | bus.out_ready;
    end

    // Select what each stage sees: bus operands for stage 0, previous stage otherwise
    always_comb begin
        w_v[0]  = bus.in_valid;
        w_x[0]  = bus.X;
        w_b[0]  = bus.op ? ~bus.Y : bus.Y;
        w_c[0]  = bus.carryin ^ bus.op;
        w_s[0]  = '0;
        w_z[0]  = 1'b1;
        w_xm[0] = bus.X[N-1];
        w_bm[0] = bus.Y[N-1] ^ bus.op;
`ifdef ADDSUB_SAT_EN
        w_sat[0] = bus.sat;
`endif
        for (int unsigned k = 1; k < STAGES; k++) begin
            w_v[k]  = r_v[k-1];
            w_x[k]  = r_x[k-1];
            w_b[k]  = r_b[k-1];
            w_c[k]  = r_c[k-1];
            w_s[k]  = r_s[k-1];
            w_z[k]  = r_z[k-1];
            w_xm[k] = r_xm[k-1];
            w_bm[k] = r_bm[k-1];
`ifdef ADDSUB_SAT_EN
            w_sat[k] = r_sat[k-1];
`endif
        end
    end

    // Chunk adders: stage k sums bits [k*W +: W] and folds its zero test in
    always_comb begin
        for (int unsigned k = 0; k < STAGES; k++) begin
            w_add[k] = {1'b0, w_x[k][k*W +: W]} + {1'b0, w_b[k][k*W +: W]}
                     + {{W{1'b0}}, w_c[k]};
            w_sn[k]  = w_s[k];
            w_sn[k][k*W +: W] = w_add[k][W-1:0];
            w_zn[k]  = w_z[k] & ~(|w_add[k][W-1:0]);
        end
    end

    // Pipeline registers: shift every stage together on advance, else hold
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                r_v[k]  <= 1'b0;
                r_x[k]  <= '0;
                r_b[k]  <= '0;
                r_s[k]  <= '0;
                r_c[k]  <= 1'b0;
                r_z[k]  <= 1'b0;
                r_xm[k] <= 1'b0;
                r_bm[k] <= 1'b0;
`ifdef ADDSUB_SAT_EN
                r_sat[k] <= 1'b0;
`endif
            end
        end else if (w_adv) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                r_v[k]  <= w_v[k];
                r_x[k]  <= w_x[k];
                r_b[k]  <= w_b[k];
                r_s[k]  <= w_sn[k];
                r_c[k]  <= w_add[k][W];
                r_z[k]  <= w_zn[k];
                r_xm[k] <= w_xm[k];
                r_bm[k] <= w_bm[k];
`ifdef ADDSUB_SAT_EN
                r_sat[k] <= w_sat[k];
`endif
            end
        end
    end

    // Output flags from the last stage; clamping happens here so it costs no cycle
    always_comb begin
        w_s_raw = r_s[L];
        w_ovf   = r_xm[L] ^ r_bm[L] ^ w_s_raw[N-1] ^ r_c[L];
`ifdef ADDSUB_SAT_EN
        if (r_sat[L] && w_ovf) begin
            bus.S    = r_xm[L] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
            bus.zero = 1'b0;
        end else begin
            bus.S    = w_s_raw;
            bus.zero = r_z[L];
        end
`else
        bus.S    = w_s_raw;
        bus.zero = r_z[L];
`endif
        bus.negative  = bus.S[N-1];
        bus.overflow  = w_ovf;
        bus.carryout  = r_c[L];
        bus.out_valid = r_v[L];
        bus.in_ready  = w_adv;
    end
endmodule

// File: tb/tb_addsub_pipe.sv
// Directed self-checking bench for addsub_pipe (N=32, STAGES=4).
// Covers reset state, latency, flag corner cases, backpressure ordering and
// asynchronous reset with beats in flight; sat clamping with ADDSUB_SAT_EN.
module tb_addsub_pipe;
    localparam int N      = 32;
    localparam int STAGES = 4;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    addsub_pipe_if #(.N(N)) bus ();

    addsub_pipe #(.N(N), .STAGES(STAGES)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One isolated beat: checks latency, then S and all flags
    task automatic run_one(input string tag, input logic op, input logic cin,
                           input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] es, input logic eco, input logic eov,
                           input logic ez, input logic en);
        int lat;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.op        = op;
        bus.carryin   = cin;
        bus.X         = x;
        bus.Y         = y;
        #1;
        chk({tag, "_in_ready"}, {31'b0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 16) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, STAGES);
        chk({tag, "_S"}, bus.S, es);
        chk({tag, "_carryout"}, {31'b0, bus.carryout}, {31'b0, eco});
        chk({tag, "_overflow"}, {31'b0, bus.overflow}, {31'b0, eov});
        chk({tag, "_zero"}, {31'b0, bus.zero}, {31'b0, ez});
        chk({tag, "_negative"}, {31'b0, bus.negative}, {31'b0, en});
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] bp_x [6];
        logic [31:0] bp_y [6];
        logic [31:0] bp_s [6];
        logic        bp_op[6];
        logic        bp_co[6];
        logic [31:0] held;
        int          tx;
        int          outs;
        logic        acc;

        bus.in_valid  = 1'b0;
        bus.op        = 1'b0;
        bus.carryin   = 1'b0;
        bus.X         = '0;
        bus.Y         = '0;
        bus.out_ready = 1'b0;
`ifdef ADDSUB_SAT_EN
        bus.sat       = 1'b0;
`endif

        // Reset state
        tick();
        tick();
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_S", bus.S, 32'h0);
        chk("rst_carryout", {31'b0, bus.carryout}, 32'd0);
        chk("rst_overflow", {31'b0, bus.overflow}, 32'd0);
        chk("rst_zero", {31'b0, bus.zero}, 32'd0);
        chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        @(negedge clock);
        resetn = 1'b1;
        tick();

        // Single beats:      op  cin  X             Y             S             co   ov   z    n
        run_one("ovf_add",    0,  0,   32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0,   1,   0,   1);
        run_one("wrap_add",   0,  0,   32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1,   0,   1,   0);
        run_one("sub_borrow", 1,  0,   32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 0,   0,   0,   1);
        run_one("sub_cin",    1,  1,   32'h0000_0007, 32'h0000_0005, 32'h0000_0001, 1,   0,   0,   0);
        run_one("add_cin",    0,  1,   32'h0000_00FF, 32'h0000_0000, 32'h0000_0100, 0,   0,   0,   0);
        run_one("sub_novf",   1,  0,   32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1,   1,   0,   0);
`ifdef ADDSUB_SAT_EN
        bus.sat = 1'b1;
        run_one("sat_pos",    0,  0,   32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 0,   1,   0,   0);
        run_one("sat_neg",    1,  0,   32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1,   1,   0,   1);
        run_one("sat_inrange",0,  0,   32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 0,   0,   0,   0);
        bus.sat = 1'b0;
`endif

        // Backpressure: 6 back-to-back beats, out_ready low for cycles 5..8
        bp_x[0] = 32'h0000_0001; bp_y[0] = 32'h0000_0002; bp_op[0] = 0; bp_s[0] = 32'h0000_0003; bp_co[0] = 0;
        bp_x[1] = 32'h0000_0010; bp_y[1] = 32'h0000_0020; bp_op[1] = 0; bp_s[1] = 32'h0000_0030; bp_co[1] = 0;
        bp_x[2] = 32'h0000_0100; bp_y[2] = 32'h0000_0001; bp_op[2] = 1; bp_s[2] = 32'h0000_00FF; bp_co[2] = 1;
        bp_x[3] = 32'h0000_FFFF; bp_y[3] = 32'h0000_0001; bp_op[3] = 0; bp_s[3] = 32'h0001_0000; bp_co[3] = 0;
        bp_x[4] = 32'h0001_0000; bp_y[4] = 32'h0000_0001; bp_op[4] = 1; bp_s[4] = 32'h0000_FFFF; bp_co[4] = 1;
        bp_x[5] = 32'h00FF_FFFF; bp_y[5] = 32'h0000_0001; bp_op[5] = 0; bp_s[5] = 32'h0100_0000; bp_co[5] = 0;
        tx   = 0;
        outs = 0;
        held = '0;
        bus.carryin = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            bus.out_ready = !(cyc >= 5 && cyc <= 8);
            bus.in_valid  = (tx < 6);
            if (tx < 6) begin
                bus.X  = bp_x[tx];
                bus.Y  = bp_y[tx];
                bus.op = bp_op[tx];
            end
            #1;
            if (cyc >= 5 && cyc <= 8) begin
                chk("bp_in_ready_low", {31'b0, bus.in_ready}, 32'd0);
                chk("bp_out_valid_held", {31'b0, bus.out_valid}, 32'd1);
                if (cyc == 5) held = bus.S;
                else chk("bp_S_stable", bus.S, held);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (outs < 6) begin
                    chk($sformatf("bp_S_%0d", outs), bus.S, bp_s[outs]);
                    chk($sformatf("bp_co_%0d", outs), {31'b0, bus.carryout}, {31'b0, bp_co[outs]});
                end
                outs++;
            end
            acc = bus.in_valid && bus.in_ready;
            tick();
            if (acc) tx++;
        end
        chk("bp_beats_out", outs, 6);
        chk("bp_beats_in", tx, 6);
        bus.in_valid = 1'b0;

        // Asynchronous reset with three beats in flight and the output held
        bus.out_ready = 1'b0;
        bus.op        = 1'b0;
        bus.X         = 32'hFFFF_FFFF;
        bus.Y         = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        chk("ar_pre_out_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("ar_pre_S", bus.S, 32'hFFFF_FFFE);
        chk("ar_pre_carryout", {31'b0, bus.carryout}, 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("ar_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("ar_S", bus.S, 32'h0);
        chk("ar_carryout", {31'b0, bus.carryout}, 32'd0);
        chk("ar_overflow", {31'b0, bus.overflow}, 32'd0);
        chk("ar_zero", {31'b0, bus.zero}, 32'd0);
        chk("ar_negative", {31'b0, bus.negative}, 32'd0);
        chk("ar_in_ready", {31'b0, bus.in_ready}, 32'd1);
        @(negedge clock);
        resetn = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("ar_no_stale", {31'b0, bus.out_valid}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
